caesar_decoder: RTL

Streaming Caesar-cipher decoder: the receive-side counterpart of the team's `caesar_cipher` encoder. It accepts one ASCII byte per cycle over a valid/ready handshake and rotates A–Z and a–z backward by a runtime-loadable key. Case is preserved and all other bytes pass through unchanged. It sits between the byte-stream source (UART RX / FIFO) and the consumer, with a two-stage registered pipeline and full backpressure.

---
 rtl/caesar_decoder.sv | 108 ++++++++++
 1 files changed

// File: rtl/caesar_decoder.sv
// Streaming Caesar-cipher decoder: rotates A-Z / a-z backward by a loadable key through a
// two-stage valid/ready pipeline with full backpressure and an output byte counter.
module caesar_decoder #(
  parameter int unsigned DEFAULT_SHIFT = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [4:0]       key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic [4:0]       key,
  output logic [CNT_W-1:0] char_count
);

  localparam logic [4:0] DefKey = 5'(DEFAULT_SHIFT % 26);

  logic [4:0]       key_q, key_d;
  logic             s1_valid_q;
  logic [7:0]       s1_char_q;
  logic [4:0]       s1_key_q;
  logic             s2_valid_q;
  logic [7:0]       s2_char_q;
  logic [CNT_W-1:0] cnt_q;

  logic       s1_adv, s2_adv, accept, out_xfer;
  logic [7:0] dec_char, base, off;
  logic       is_alpha;

  // Advance chain: a stall at the output ripples back to in_ready in the same cycle.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !rst;
    accept   = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  always_comb begin
    key_d = key_q;
    if (key_load) begin
      key_d = (key_in >= 5'd26) ? (key_in - 5'd26) : key_in;
    end
  end

  // Backward rotation; offset + 26 - key stays within 1..51, so one conditional subtract suffices.
  always_comb begin
    base     = 8'h00;
    is_alpha = 1'b0;
    off      = 8'h00;
    dec_char = s1_char_q;
    if (s1_char_q >= 8'h41 && s1_char_q <= 8'h5A) begin
      base     = 8'h41;
      is_alpha = 1'b1;
    end else if (s1_char_q >= 8'h61 && s1_char_q <= 8'h7A) begin
      base     = 8'h61;
      is_alpha = 1'b1;
    end
    if (is_alpha) begin
      off = s1_char_q - base + 8'd26 - {3'b000, s1_key_q};
      if (off >= 8'd26) begin
        off = off - 8'd26;
      end
      dec_char = base + off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= DefKey;
      s1_valid_q <= 1'b0;
      s1_char_q  <= 8'h00;
      s1_key_q   <= DefKey;
      s2_valid_q <= 1'b0;
      s2_char_q  <= 8'h00;
      cnt_q      <= '0;
    end else begin
      key_q <= key_d;
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_char_q <= in_char;
          s1_key_q  <= key_q;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_char_q <= dec_char;
        end
      end
      if (out_xfer) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_char   = s2_char_q;
  assign key        = key_q;
  assign char_count = cnt_q;

endmodule
